// File: rtl/issue_queue.sv
// issue_queue: unified age-ordered issue queue between DC_stage and the
// functional-unit / register-read stage.
//
// Entries are kept compacted with index 0 the oldest. Each cycle the oldest
// entry with both sources ready is offered on issue_*. When it fires, every
// younger entry shifts down one slot, and a new insert lands in the first
// free slot after that shift.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   DC_valid, DC_out_* renamed instruction from DC_stage
//   IS_ready          queue can take an insert this cycle (registered count only)
//   rs1_busy/rs2_busy busy-table lookups for DC_out_P_rs1/P_rs2
//   wb_valid, wb_preg CDB wakeup broadcast
//   issue_valid/ready issue handshake; issue_* payload of the selected entry
//   mispredict        flush every entry (beats insert, fire and wakeup)
//   stall             block inserts only
//   iq_count          occupied entries
//
// Build option
//   IQ_WAKEUP_BYPASS_EN  when defined, a CDB broadcast also counts as ready in
//                        the same cycle's select, so a woken entry can issue
//                        together with its broadcast. When undefined, select
//                        only looks at registered ready bits.

// Per-entry source tracking: sticky ready bits updated by the CDB, plus the
// readiness view that select uses.
module issue_queue_wake #(
  parameter int PRW = 7
) (
  input  logic [PRW-1:0] tag1,
  input  logic [PRW-1:0] tag2,
  input  logic           rdy1,
  input  logic           rdy2,
  input  logic           wb_valid,
  input  logic [PRW-1:0] wb_preg,
  output logic           rdy1_nxt,
  output logic           rdy2_nxt,
  output logic           sel1,
  output logic           sel2
);
  logic hit1, hit2;

  assign hit1     = wb_valid && (wb_preg == tag1);
  assign hit2     = wb_valid && (wb_preg == tag2);
  assign rdy1_nxt = rdy1 | hit1;
  assign rdy2_nxt = rdy2 | hit2;

`ifdef IQ_WAKEUP_BYPASS_EN
  assign sel1 = rdy1 | hit1;
  assign sel2 = rdy2 | hit2;
`else
  assign sel1 = rdy1;
  assign sel2 = rdy2;
`endif
endmodule

module issue_queue #(
  parameter int DEPTH = 4,
  parameter int PRW   = 7,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           DC_valid,
  input  logic [31:0]    DC_out_pc,
  input  logic [31:0]    DC_out_inst,
  input  logic [31:0]    DC_out_imm,
  input  logic [4:0]     DC_out_op,
  input  logic [2:0]     DC_out_f3,
  input  logic [6:0]     DC_out_f7,
  input  logic [PRW-1:0] DC_out_P_rs1,
  input  logic [PRW-1:0] DC_out_P_rs2,
  input  logic [PRW-1:0] DC_out_P_rd,
  input  logic [2:0]     DC_out_fu_sel,
  input  logic [2:0]     DC_out_rob_idx,
  input  logic [1:0]     DC_out_LQ_tail,
  input  logic [1:0]     DC_out_SQ_tail,
  output logic           IS_ready,
  input  logic           rs1_busy,
  input  logic           rs2_busy,
  input  logic           wb_valid,
  input  logic [PRW-1:0] wb_preg,
  output logic           issue_valid,
  input  logic           issue_ready,
  output logic [31:0]    issue_pc,
  output logic [31:0]    issue_inst,
  output logic [31:0]    issue_imm,
  output logic [4:0]     issue_op,
  output logic [2:0]     issue_f3,
  output logic [6:0]     issue_f7,
  output logic [PRW-1:0] issue_P_rs1,
  output logic [PRW-1:0] issue_P_rs2,
  output logic [PRW-1:0] issue_P_rd,
  output logic [2:0]     issue_fu_sel,
  output logic [2:0]     issue_rob_idx,
  output logic [1:0]     issue_LQ_tail,
  output logic [1:0]     issue_SQ_tail,
  input  logic           mispredict,
  input  logic           stall,
  output logic [CW-1:0]  iq_count
);
  // Opcode[6:2] encodings, identical to the ones DC_stage decodes.
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam logic [4:0] R_TYPE    = 5'b01100;
  localparam logic [4:0] F_TYPE    = 5'b10100;
  localparam logic [4:0] S_TYPE    = 5'b01000;
  localparam logic [4:0] FSTORE    = 5'b01001;
  localparam logic [4:0] B_TYPE    = 5'b11000;

  typedef struct packed {
    logic [31:0]    pc;
    logic [31:0]    inst;
    logic [31:0]    imm;
    logic [4:0]     op;
    logic [2:0]     f3;
    logic [6:0]     f7;
    logic [PRW-1:0] p_rs1;
    logic [PRW-1:0] p_rs2;
    logic [PRW-1:0] p_rd;
    logic [2:0]     fu_sel;
    logic [2:0]     rob_idx;
    logic [1:0]     lq_tail;
    logic [1:0]     sq_tail;
    logic           rdy1;
    logic           rdy2;
  } iq_ent_t;

  iq_ent_t         ent_q   [DEPTH];
  iq_ent_t         ent_nxt [DEPTH];
  iq_ent_t         ent_ext [DEPTH+1];  // woken entries, plus an empty slot on top for the shift
  iq_ent_t         ins_ent;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [DEPTH-1:0] wk1, wk2, sel1, sel2, can_sel;
  logic            sel_found, fire, insert;
  logic            use1, use2;
  int              sel_i, ins_i;

  // ---------------------------------------------------------------- handshake
  // IS_ready looks only at the registered count so it never depends on this
  // cycle's issue; a full queue stays closed for one cycle even if it fires.
  assign IS_ready    = (cnt_q != CW'(DEPTH)) && !mispredict && !stall;
  assign issue_valid = sel_found && !mispredict && !rst;
  assign iq_count    = cnt_q;
  assign fire        = issue_valid && issue_ready;
  assign insert      = DC_valid && IS_ready;

  // ---------------------------------------------------------------- per entry
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    issue_queue_wake #(.PRW(PRW)) u_wake (
      .tag1     (ent_q[g].p_rs1),
      .tag2     (ent_q[g].p_rs2),
      .rdy1     (ent_q[g].rdy1),
      .rdy2     (ent_q[g].rdy2),
      .wb_valid (wb_valid),
      .wb_preg  (wb_preg),
      .rdy1_nxt (wk1[g]),
      .rdy2_nxt (wk2[g]),
      .sel1     (sel1[g]),
      .sel2     (sel2[g])
    );
    assign can_sel[g] = (CW'(g) < cnt_q) && sel1[g] && sel2[g];
  end

  // ---------------------------------------------------------------- select
  // Descending scan so the lowest (oldest) ready index wins.
  always_comb begin
    sel_found     = 1'b0;
    sel_i         = 0;
    issue_pc      = '0;
    issue_inst    = '0;
    issue_imm     = '0;
    issue_op      = '0;
    issue_f3      = '0;
    issue_f7      = '0;
    issue_P_rs1   = '0;
    issue_P_rs2   = '0;
    issue_P_rd    = '0;
    issue_fu_sel  = '0;
    issue_rob_idx = '0;
    issue_LQ_tail = '0;
    issue_SQ_tail = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (can_sel[i]) begin
        sel_found     = 1'b1;
        sel_i         = i;
        issue_pc      = ent_q[i].pc;
        issue_inst    = ent_q[i].inst;
        issue_imm     = ent_q[i].imm;
        issue_op      = ent_q[i].op;
        issue_f3      = ent_q[i].f3;
        issue_f7      = ent_q[i].f7;
        issue_P_rs1   = ent_q[i].p_rs1;
        issue_P_rs2   = ent_q[i].p_rs2;
        issue_P_rd    = ent_q[i].p_rd;
        issue_fu_sel  = ent_q[i].fu_sel;
        issue_rob_idx = ent_q[i].rob_idx;
        issue_LQ_tail = ent_q[i].lq_tail;
        issue_SQ_tail = ent_q[i].sq_tail;
      end
    end
  end

  // ---------------------------------------------------------------- insert
  always_comb begin
    use1 = !((DC_out_op == OP_LUI) || (DC_out_op == OP_AUIPC) || (DC_out_op == OP_JAL) ||
             ((DC_out_op == OP_SYSTEM) && DC_out_f3[2]));
    use2 = (DC_out_op == R_TYPE) || (DC_out_op == F_TYPE) || (DC_out_op == S_TYPE) ||
           (DC_out_op == FSTORE) || (DC_out_op == B_TYPE);

    ins_ent         = '0;
    ins_ent.pc      = DC_out_pc;
    ins_ent.inst    = DC_out_inst;
    ins_ent.imm     = DC_out_imm;
    ins_ent.op      = DC_out_op;
    ins_ent.f3      = DC_out_f3;
    ins_ent.f7      = DC_out_f7;
    ins_ent.p_rs1   = DC_out_P_rs1;
    ins_ent.p_rs2   = DC_out_P_rs2;
    ins_ent.p_rd    = DC_out_P_rd;
    ins_ent.fu_sel  = DC_out_fu_sel;
    ins_ent.rob_idx = DC_out_rob_idx;
    ins_ent.lq_tail = DC_out_LQ_tail;
    ins_ent.sq_tail = DC_out_SQ_tail;
    // A broadcast in the insert cycle must count, or the entry would wait forever.
    ins_ent.rdy1    = !use1 || (DC_out_P_rs1 == '0) || !rs1_busy ||
                      (wb_valid && (wb_preg == DC_out_P_rs1));
    ins_ent.rdy2    = !use2 || (DC_out_P_rs2 == '0) || !rs2_busy ||
                      (wb_valid && (wb_preg == DC_out_P_rs2));
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_ext[i]      = ent_q[i];
      ent_ext[i].rdy1 = wk1[i];
      ent_ext[i].rdy2 = wk2[i];
    end
    ent_ext[DEPTH] = '0;
  end

  always_comb begin
    ins_i   = int'(cnt_q) - (fire ? 1 : 0);
    cnt_nxt = cnt_q - CW'(fire) + CW'(insert);
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = '0;
      // Slots at or above the fired entry pull from one above; slots past the
      // surviving count are cleared so stale tags never wake.
      if (fire && (i >= sel_i)) begin
        if (i + 1 < int'(cnt_q)) ent_nxt[i] = ent_ext[i+1];
      end else begin
        if (i < int'(cnt_q)) ent_nxt[i] = ent_ext[i];
      end
      if (insert && (i == ins_i)) ent_nxt[i] = ins_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_nxt[i];
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  localparam logic [4:0] OP_R   = 5'b01100;
  localparam logic [4:0] OP_IMM = 5'b00100;

  logic        clk = 1'b0;
  logic        rst;
  logic        DC_valid;
  logic [31:0] DC_out_pc, DC_out_inst, DC_out_imm;
  logic [4:0]  DC_out_op;
  logic [2:0]  DC_out_f3;
  logic [6:0]  DC_out_f7;
  logic [6:0]  DC_out_P_rs1, DC_out_P_rs2, DC_out_P_rd;
  logic [2:0]  DC_out_fu_sel, DC_out_rob_idx;
  logic [1:0]  DC_out_LQ_tail, DC_out_SQ_tail;
  logic        IS_ready, rs1_busy, rs2_busy, wb_valid;
  logic [6:0]  wb_preg;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_pc, issue_inst, issue_imm;
  logic [4:0]  issue_op;
  logic [2:0]  issue_f3;
  logic [6:0]  issue_f7;
  logic [6:0]  issue_P_rs1, issue_P_rs2, issue_P_rd;
  logic [2:0]  issue_fu_sel, issue_rob_idx;
  logic [1:0]  issue_LQ_tail, issue_SQ_tail;
  logic        mispredict, stall;
  logic [2:0]  iq_count;

  issue_queue #(.DEPTH(4), .PRW(7)) dut (
    .clk(clk), .rst(rst), .DC_valid(DC_valid),
    .DC_out_pc(DC_out_pc), .DC_out_inst(DC_out_inst), .DC_out_imm(DC_out_imm),
    .DC_out_op(DC_out_op), .DC_out_f3(DC_out_f3), .DC_out_f7(DC_out_f7),
    .DC_out_P_rs1(DC_out_P_rs1), .DC_out_P_rs2(DC_out_P_rs2), .DC_out_P_rd(DC_out_P_rd),
    .DC_out_fu_sel(DC_out_fu_sel), .DC_out_rob_idx(DC_out_rob_idx),
    .DC_out_LQ_tail(DC_out_LQ_tail), .DC_out_SQ_tail(DC_out_SQ_tail),
    .IS_ready(IS_ready), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_inst(issue_inst), .issue_imm(issue_imm),
    .issue_op(issue_op), .issue_f3(issue_f3), .issue_f7(issue_f7),
    .issue_P_rs1(issue_P_rs1), .issue_P_rs2(issue_P_rs2), .issue_P_rd(issue_P_rd),
    .issue_fu_sel(issue_fu_sel), .issue_rob_idx(issue_rob_idx),
    .issue_LQ_tail(issue_LQ_tail), .issue_SQ_tail(issue_SQ_tail),
    .mispredict(mispredict), .stall(stall), .iq_count(iq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [6:0] rd);
    exp_t e;
    e.pc = pc;
    e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic drv(input logic [31:0] pc, input logic [4:0] op, input logic [6:0] rs1,
                     input logic [6:0] rs2, input logic [6:0] rd, input logic b1, input logic b2);
    DC_valid       = 1'b1;
    DC_out_pc      = pc;
    DC_out_inst    = pc ^ 32'hA5A5_0000;
    DC_out_imm     = pc + 32'd4;
    DC_out_op      = op;
    DC_out_f3      = 3'd0;
    DC_out_f7      = 7'd0;
    DC_out_P_rs1   = rs1;
    DC_out_P_rs2   = rs2;
    DC_out_P_rd    = rd;
    DC_out_fu_sel  = 3'd1;
    DC_out_rob_idx = pc[4:2];
    DC_out_LQ_tail = 2'd0;
    DC_out_SQ_tail = 2'd0;
    rs1_busy       = b1;
    rs2_busy       = b2;
  endtask

  // Every fire pops the next expected instruction.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'(issue_pc), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("issue_pc",   64'(issue_pc),      64'(e.pc));
        chk("issue_rd",   64'(issue_P_rd),    64'(e.rd));
        chk("issue_inst", 64'(issue_inst),    64'(e.pc ^ 32'hA5A5_0000));
        chk("issue_rob",  64'(issue_rob_idx), 64'(e.pc[4:2]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic        exp_rdy;
    rst = 1'b1; DC_valid = 1'b0; mispredict = 1'b0; stall = 1'b0;
    wb_valid = 1'b0; wb_preg = '0; issue_ready = 1'b0;
    drv(32'h0, OP_R, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0);
    DC_valid = 1'b0;
    step(); step(); mid();
    chk("rst_count", 64'(iq_count),    64'd0);
    chk("rst_isrdy", 64'(IS_ready),    64'd1);
    chk("rst_iv",    64'(issue_valid), 64'd0);
    chk("rst_pc",    64'(issue_pc),    64'd0);

    // T1: single ready ADD
    step(); rst = 1'b0; issue_ready = 1'b1;
    drv(32'h100, OP_R, 7'd5, 7'd6, 7'd10, 1'b0, 1'b0); push(32'h100, 7'd10);
    mid(); chk("t1_iv_same", 64'(issue_valid), 64'd0);
    step(); DC_valid = 1'b0;
    mid(); chk("t1_iv", 64'(issue_valid), 64'd1); chk("t1_cnt1", 64'(iq_count), 64'd1);
    step(); mid(); chk("t1_cnt0", 64'(iq_count), 64'd0);

    // T2: fill with entries waiting on P9 (rs2 = P0 busy is still ready)
    for (int k = 0; k < 4; k++) begin
      step(); drv(32'h200 + 32'(4*k), OP_R, 7'd9, 7'd0, 7'(20+k), 1'b1, 1'b1);
      push(32'h200 + 32'(4*k), 7'(20+k));
      mid(); chk("t2_iv", 64'(issue_valid), 64'd0);
    end
    step(); drv(32'h210, OP_R, 7'd9, 7'd0, 7'd24, 1'b0, 1'b0);
    mid();
    chk("t2_cnt", 64'(iq_count), 64'd4);
    chk("t2_isrdy", 64'(IS_ready), 64'd0);
    chk("t2_iv", 64'(issue_valid), 64'd0);

    // T3: wake P9, drain in order
    step(); DC_valid = 1'b0; wb_valid = 1'b1; wb_preg = 7'd9;
    mid();
`ifdef IQ_WAKEUP_BYPASS_EN
    chk("t3_iv_bcast", 64'(issue_valid), 64'd1);
`else
    chk("t3_iv_bcast", 64'(issue_valid), 64'd0);
`endif
    step(); wb_valid = 1'b0;
    mid(); chk("t3_iv_next", 64'(issue_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin step(); mid(); end
    chk("t3_cnt", 64'(iq_count), 64'd0);

    // T4: younger ready entry bypasses older waiter
    step(); drv(32'h300, OP_R, 7'd12, 7'd0, 7'd30, 1'b1, 1'b0); mid();
    step(); drv(32'h304, OP_R, 7'd13, 7'd0, 7'd31, 1'b0, 1'b0); push(32'h304, 7'd31);
    mid(); chk("t4_iv_wait", 64'(issue_valid), 64'd0);
    step(); drv(32'h308, OP_R, 7'd12, 7'd0, 7'd32, 1'b1, 1'b0);
    mid(); chk("t4_b_first", 64'(issue_pc), 64'h304);
    step(); DC_valid = 1'b0;
    mid(); chk("t4_cnt", 64'(iq_count), 64'd2); chk("t4_iv", 64'(issue_valid), 64'd0);
    step(); wb_valid = 1'b1; wb_preg = 7'd12; push(32'h300, 7'd30); push(32'h308, 7'd32);
    mid();
    step(); wb_valid = 1'b0;
    mid(); chk("t4_iv_after", 64'(issue_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin step(); mid(); end
    chk("t4_cnt0", 64'(iq_count), 64'd0);

    // T5: mispredict beats insert and wakeup
    for (int k = 0; k < 3; k++) begin
      step(); drv(32'h400 + 32'(4*k), OP_R, 7'd40, 7'd0, 7'(50+k), 1'b1, 1'b0); mid();
    end
    step(); drv(32'h40C, OP_R, 7'd41, 7'd0, 7'd53, 1'b0, 1'b0);
    mispredict = 1'b1; wb_valid = 1'b1; wb_preg = 7'd40;
    mid(); chk("t5_iv", 64'(issue_valid), 64'd0); chk("t5_isrdy", 64'(IS_ready), 64'd0);
    step(); mispredict = 1'b0; DC_valid = 1'b0; wb_valid = 1'b0;
    mid(); chk("t5_cnt", 64'(iq_count), 64'd0); chk("t5_iv_next", 64'(issue_valid), 64'd0);
    step(); mid(); chk("t5_iv_later", 64'(issue_valid), 64'd0);

    // stall blocks insert
    step(); stall = 1'b1; drv(32'h450, OP_R, 7'd1, 7'd2, 7'd3, 1'b0, 1'b0);
    mid(); chk("stall_isrdy", 64'(IS_ready), 64'd0);
    step(); stall = 1'b0; DC_valid = 1'b0;
    mid(); chk("stall_cnt", 64'(iq_count), 64'd0);

    // T7: same-cycle wakeup at insert; rs2 unused by OP-IMM even if busy
    step(); drv(32'h600, OP_IMM, 7'd50, 7'd51, 7'd60, 1'b1, 1'b1);
    wb_valid = 1'b1; wb_preg = 7'd50; push(32'h600, 7'd60);
    mid(); chk("t7_iv_same", 64'(issue_valid), 64'd0);
    step(); DC_valid = 1'b0; wb_valid = 1'b0;
    mid(); chk("t7_iv", 64'(issue_valid), 64'd1);
    step(); mid(); chk("t7_cnt", 64'(iq_count), 64'd0);

    // T6: full queue, steady insert + fire
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); drv(32'h500 + 32'(4*k), OP_R, 7'd1, 7'd2, 7'(40+k), 1'b0, 1'b0);
      push(32'h500 + 32'(4*k), 7'(40+k));
      mid();
      if (k > 0) chk("t6_hold_pc", 64'(issue_pc), 64'h500);
    end
    pc = 32'h510;
    for (int j = 0; j < 6; j++) begin
      step(); issue_ready = 1'b1;
      exp_rdy = (j > 0);
      drv(pc, OP_R, 7'd1, 7'd2, 7'(pc[6:0]), 1'b0, 1'b0);
      if (exp_rdy) begin push(pc, 7'(pc[6:0])); end
      mid();
      chk("t6_isrdy", 64'(IS_ready), 64'(exp_rdy));
      chk("t6_cnt", 64'(iq_count), (j == 0) ? 64'd4 : 64'd3);
      if (exp_rdy) pc = pc + 32'd4;
    end
    step(); DC_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin step(); mid(); end
    chk("t6_cnt0", 64'(iq_count), 64'd0);

    // rst mid-operation clears everything
    step(); drv(32'h700, OP_R, 7'd70, 7'd0, 7'd70, 1'b1, 1'b0); mid();
    step(); drv(32'h704, OP_R, 7'd70, 7'd0, 7'd71, 1'b1, 1'b0); mid();
    step(); DC_valid = 1'b0; rst = 1'b1;
    mid(); chk("rst2_iv", 64'(issue_valid), 64'd0);
    step(); rst = 1'b0;
    mid();
    chk("rst2_cnt", 64'(iq_count), 64'd0);
    chk("rst2_pc", 64'(issue_pc), 64'd0);
    chk("rst2_isrdy", 64'(IS_ready), 64'd1);
    step(); wb_valid = 1'b1; wb_preg = 7'd70; mid();
    step(); wb_valid = 1'b0;
    mid(); chk("rst2_iv_after", 64'(issue_valid), 64'd0);

    step(); mid();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
